// File: rtl/game_pkg.sv
// Shared types and constants for the game datapath.
// Holds the LFSR step and index wrap helpers.
package game_pkg;

  localparam int LED_IDX_W = 4;
  localparam int NUM_LEDS_DEF = 15;
  localparam int LFSR_W = 16;
  localparam int MAX_TRIES_DEF = 8;

  localparam logic [LFSR_W-1:0] LFSR_TAPS =
    16'hB400;
  localparam logic [LFSR_W-1:0] SEED_DEF =
    16'hACE1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_DRAW = ST_DRAW,
    S_HOLD = ST_HOLD
  } rlg_state_t;

  typedef logic [LED_IDX_W-1:0] led_idx_t;

  function automatic logic [LFSR_W-1:0]
    lfsr_next(input logic [LFSR_W-1:0] v);
    logic [LFSR_W-1:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ LFSR_TAPS;
    return s;
  endfunction

  // Successor of an index, wrapping to 0 at n.
  function automatic led_idx_t wrap_inc(
    input led_idx_t v,
    input logic [LED_IDX_W:0] n
  );
    logic [LED_IDX_W:0] s;
    s = {1'b0, v} + (LED_IDX_W+1)'(1);
    if (s == n) return '0;
    return s[LED_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/random_led_gen_if.sv
// Controller-facing bundle of the round index generator.
// master drives requests/seeds, slave returns the index.
interface random_led_gen_if;
  import game_pkg::*;

  logic enable_game;
  logic seed_load;
  logic [LFSR_W-1:0] seed_in;
  logic next_req;
  led_idx_t random_out;
  logic rnd_valid;
  logic busy;

  modport master (
    output enable_game,
    output seed_load,
    output seed_in,
    output next_req,
    input random_out,
    input rnd_valid,
    input busy
  );

  modport slave (
    input enable_game,
    input seed_load,
    input seed_in,
    input next_req,
    output random_out,
    output rnd_valid,
    output busy
  );

endinterface

// File: rtl/lfsr16.sv
// 16-bit right-shift Galois LFSR with seed load.
// A zero state or zero seed is replaced by SEED.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = SEED_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  input  logic load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] seed_val;

  assign seed_val = (load_val == '0) ? SEED
                                     : load_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else if (load) begin
      q <= seed_val;
    end else if (q == '0) begin
      q <= SEED;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/random_led_gen.sv
// Per-round target LED index generator for mini_game.
// Draws from an LFSR, never repeats the previous index.
module random_led_gen
  import game_pkg::*;
#(
  parameter int NUM_LEDS = NUM_LEDS_DEF,
  parameter logic [LFSR_W-1:0] SEED = SEED_DEF,
  parameter int MAX_TRIES = MAX_TRIES_DEF
) (
  input logic clk,
  input logic reset,
  random_led_gen_if.slave bus
);

  localparam int TRY_W =
    (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [LED_IDX_W:0] NUM =
    (LED_IDX_W+1)'(NUM_LEDS);
  localparam logic [TRY_W-1:0] LAST_TRY =
    TRY_W'(MAX_TRIES - 1);

  rlg_state_t state;
  rlg_state_t state_nxt;

  logic [TRY_W-1:0] tries;
  logic [TRY_W-1:0] tries_nxt;
  led_idx_t out_idx;
  led_idx_t out_nxt;
  led_idx_t last;
  led_idx_t last_nxt;
  logic last_valid;
  logic last_valid_nxt;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-LED_IDX_W-1:0] lfsr_unused;
  led_idx_t cand;
  led_idx_t fallback;
  logic in_range;
  logic fresh;
  logic accept;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk(clk),
    .reset(reset),
    .step(bus.enable_game),
    .load(bus.seed_load),
    .load_val(bus.seed_in),
    .q(lfsr_q)
  );

  assign cand = lfsr_q[LED_IDX_W-1:0];
  assign lfsr_unused = lfsr_q[LFSR_W-1:LED_IDX_W];

  assign in_range = ({1'b0, cand} < NUM);
  assign fresh = !last_valid || (cand != last);
  assign accept = in_range && fresh;

  assign fallback = last_valid ? wrap_inc(last, NUM)
                               : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      tries <= '0;
      out_idx <= '0;
      last <= '0;
      last_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      tries <= tries_nxt;
      out_idx <= out_nxt;
      last <= last_nxt;
      last_valid <= last_valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tries_nxt = tries;
    out_nxt = out_idx;
    last_nxt = last;
    last_valid_nxt = last_valid;

    if (!bus.enable_game) begin
      // Leaving the game forgets history but keeps the shown index.
      state_nxt = S_IDLE;
      last_valid_nxt = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.next_req) begin
            state_nxt = S_DRAW;
            tries_nxt = '0;
          end
        end
        S_DRAW: begin
          if (accept) begin
            out_nxt = cand;
            last_nxt = cand;
            last_valid_nxt = 1'b1;
            state_nxt = S_HOLD;
          end else if (tries == LAST_TRY) begin
            out_nxt = fallback;
            last_nxt = fallback;
            last_valid_nxt = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            tries_nxt = tries + TRY_W'(1);
          end
        end
        S_HOLD: begin
          if (bus.next_req) begin
            state_nxt = S_DRAW;
            tries_nxt = '0;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign bus.random_out = out_idx;
  assign bus.rnd_valid = (state == S_HOLD);
  assign bus.busy = (state == S_DRAW);

endmodule

// File: tb/tb_random_led_gen.sv
// Directed bench for random_led_gen.
// Inputs change and outputs are sampled on the falling edge.
module tb_random_led_gen;

  logic clk = 1'b0;
  logic reset;
  int vecs = 0;
  int errs = 0;

  random_led_gen_if bus ();

  random_led_gen dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(
    input string tag,
    input logic [3:0] obs,
    input logic [3:0] exp
  );
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic expect_o(
    input string tag,
    input logic [3:0] o,
    input logic v,
    input logic b
  );
    chk({tag, ".out"}, bus.random_out, o);
    chk({tag, ".valid"}, {3'b0, bus.rnd_valid},
        {3'b0, v});
    chk({tag, ".busy"}, {3'b0, bus.busy},
        {3'b0, b});
  endtask

  // Keep the LFSR pinned at 0x000F so every candidate is 15.
  task automatic forced(
    input string tag,
    input logic [3:0] exp
  );
    bus.next_req = 1'b1;
    bus.seed_load = 1'b1;
    bus.seed_in = 16'h000F;
    step;
    bus.next_req = 1'b0;
    expect_o({tag, "_enter"}, bus.random_out,
             1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      bus.next_req = (i == 2);
      step;
      chk({tag, "_busy"}, {3'b0, bus.busy}, 4'd1);
    end
    bus.next_req = 1'b0;
    step;
    bus.seed_load = 1'b0;
    expect_o({tag, "_fb"}, exp, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    bus.enable_game = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed_in = 16'h0000;
    bus.next_req = 1'b0;
    @(negedge clk);
    expect_o("reset", 4'd0, 1'b0, 1'b0);

    reset = 1'b1;
    bus.enable_game = 1'b1;
    bus.seed_load = 1'b1;
    bus.seed_in = 16'h000F;
    step;
    bus.seed_load = 1'b0;
    bus.next_req = 1'b1;
    step;
    bus.next_req = 1'b0;
    expect_o("t1_draw", 4'd0, 1'b0, 1'b1);
    step;
    expect_o("t1_hold", 4'd7, 1'b1, 1'b0);

    bus.next_req = 1'b1;
    step;
    bus.next_req = 1'b0;
    expect_o("r2_draw", 4'd7, 1'b0, 1'b1);
    step;
    expect_o("r2_hold", 4'd1, 1'b1, 1'b0);

    bus.seed_load = 1'b1;
    bus.seed_in = 16'h0000;
    step;
    expect_o("seed0_hold", 4'd1, 1'b1, 1'b0);
    bus.seed_load = 1'b0;
    bus.next_req = 1'b1;
    step;
    bus.next_req = 1'b0;
    expect_o("seed0_draw", 4'd1, 1'b0, 1'b1);
    step;
    expect_o("seed0_done", 4'd0, 1'b1, 1'b0);

    forced("fb_first", 4'd1);
    step;
    expect_o("no_extra", 4'd1, 1'b1, 1'b0);

    bus.next_req = 1'b1;
    bus.seed_load = 1'b1;
    bus.seed_in = 16'h000D;
    step;
    bus.next_req = 1'b0;
    bus.seed_load = 1'b0;
    step;
    expect_o("idx13", 4'd13, 1'b1, 1'b0);

    forced("fb_inc", 4'd14);
    forced("fb_wrap", 4'd0);

    bus.next_req = 1'b1;
    bus.seed_load = 1'b1;
    bus.seed_in = 16'h0010;
    step;
    bus.next_req = 1'b0;
    bus.seed_load = 1'b0;
    step;
    expect_o("dup_rej", 4'd0, 1'b0, 1'b1);
    step;
    expect_o("dup_acc", 4'd8, 1'b1, 1'b0);

    bus.next_req = 1'b1;
    bus.seed_load = 1'b1;
    bus.seed_in = 16'h000E;
    step;
    bus.next_req = 1'b0;
    bus.seed_load = 1'b0;
    step;
    expect_o("idx14", 4'd14, 1'b1, 1'b0);

    bus.enable_game = 1'b0;
    step;
    expect_o("en_off", 4'd14, 1'b0, 1'b0);
    bus.next_req = 1'b1;
    step;
    bus.next_req = 1'b0;
    expect_o("req_dis", 4'd14, 1'b0, 1'b0);
    step;
    expect_o("req_dis2", 4'd14, 1'b0, 1'b0);

    bus.enable_game = 1'b1;
    bus.next_req = 1'b1;
    bus.seed_load = 1'b1;
    bus.seed_in = 16'h000E;
    step;
    bus.next_req = 1'b0;
    bus.seed_load = 1'b0;
    step;
    expect_o("lv_clr", 4'd14, 1'b1, 1'b0);

    bus.next_req = 1'b1;
    bus.seed_load = 1'b1;
    bus.seed_in = 16'h000F;
    step;
    bus.next_req = 1'b0;
    expect_o("pre_rst", 4'd14, 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1 expect_o("async_rst", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    bus.seed_load = 1'b0;
    step;
    expect_o("post_rst", 4'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
